// File: rtl/uart_rx_buffer_if.sv
// Port bundle for uart_rx_buffer: receiver strobe side, consumer pop side and status outputs.
// master = the receiver and consumer that drive the buffer; slave = the buffer itself.
interface uart_rx_buffer_if #(
    parameter int DATA_W     = 7,
    parameter int DEPTH_LOG2 = 3
);
    logic [DATA_W-1:0]   in_data;
    logic                in_ready;
    logic                in_error;
    logic                rd_en;
    logic                ovf_clr;
    logic [DATA_W-1:0]   out_data;
    logic                out_error;
    logic                out_valid;
    logic                full;
    logic [DEPTH_LOG2:0] count;
    logic                overflow;
    logic [7:0]          err_count;

    // in_ready is a one-cycle strobe with no backpressure: a character offered while the
    // buffer is full (and not popping) is dropped. rd_en pops the head only when out_valid=1.
    modport master (
        output in_data, in_ready, in_error, rd_en, ovf_clr,
        input  out_data, out_error, out_valid, full, count, overflow, err_count
    );

    modport slave (
        input  in_data, in_ready, in_error, rd_en, ovf_clr,
        output out_data, out_error, out_valid, full, count, overflow, err_count
    );
endinterface

// File: rtl/uart_rx_buffer.sv
// Show-ahead receive FIFO behind a UART receiver, with sticky overflow and parity-error count.
// Optional macro RX_DROP_PARITY_ERR_EN: parity-errored characters are counted but never stored.
module uart_rx_buffer #(
    parameter int DATA_W     = 7,
    parameter int DEPTH_LOG2 = 3
) (
    input  logic clk,
    input  logic rst,
    uart_rx_buffer_if.slave bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2+1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0] CNT_ONE   = (DEPTH_LOG2+1)'(1);
`ifdef RX_DROP_PARITY_ERR_EN
    localparam int ENTRY_W = DATA_W;
`else
    localparam int ENTRY_W = DATA_W + 1;
`endif

    logic [ENTRY_W-1:0]    mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   cnt;
    logic                  ovf;
    logic [7:0]            errc;

    logic                  not_empty;
    logic                  is_full;
    logic                  pop;
    logic                  store_ok;
    logic                  push;
    logic                  drop;
    logic                  err_strobe;
    logic [ENTRY_W-1:0]    head;

    assign not_empty  = (cnt != '0);
    assign is_full    = (cnt == DEPTH_CNT);
    assign pop        = bus.rd_en & not_empty;
`ifdef RX_DROP_PARITY_ERR_EN
    assign store_ok   = ~bus.in_error;
`else
    assign store_ok   = 1'b1;
`endif
    // A pop in the same cycle frees a slot, so a full FIFO still accepts the new character.
    assign push       = bus.in_ready & store_ok & (~is_full | pop);
    assign drop       = bus.in_ready & store_ok & is_full & ~pop;
    assign err_strobe = bus.in_ready & bus.in_error;

    // Storage is not reset; its contents are only observed while count is non-zero.
    always_ff @(posedge clk) begin
        if (push) begin
`ifdef RX_DROP_PARITY_ERR_EN
            mem[wr_ptr] <= bus.in_data;
`else
            mem[wr_ptr] <= {bus.in_error, bus.in_data};
`endif
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            ovf    <= 1'b0;
            errc   <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;

            unique case ({push, pop})
                2'b10:   cnt <= cnt + CNT_ONE;
                2'b01:   cnt <= cnt - CNT_ONE;
                default: cnt <= cnt;
            endcase

            // Set beats clear when both happen in one cycle.
            if (drop)             ovf <= 1'b1;
            else if (bus.ovf_clr) ovf <= 1'b0;

            if (err_strobe && errc != 8'hFF) errc <= errc + 8'd1;
        end
    end

    assign head          = mem[rd_ptr];
    assign bus.out_data  = not_empty ? head[DATA_W-1:0] : '0;
`ifdef RX_DROP_PARITY_ERR_EN
    assign bus.out_error = 1'b0;
`else
    assign bus.out_error = not_empty & head[DATA_W];
`endif
    assign bus.out_valid = not_empty;
    assign bus.full      = is_full;
    assign bus.count     = cnt;
    assign bus.overflow  = ovf;
    assign bus.err_count = errc;
endmodule

// File: doc/uart_rx_buffer.md
Name: uart_rx_buffer

Overview:
Receive-side buffer that sits directly downstream of the UART receiver. It captures each received 7-bit character and its parity-error flag on the receiver's one-cycle ready strobe, and stores them in a show-ahead FIFO. A consumer (LED display, command parser) reads entries with a pop strobe. The block also tracks overflow and parity-error statistics so that bursts of characters are not lost between consumer reads.

Parameters:
DATA_W, 7, width of one received character
DEPTH_LOG2, 3, log2 of FIFO depth (DEPTH = 8 entries)

Ports:
clk  input  1  system clock (50 MHz)
rst  input  1  asynchronous, active-low reset (0 = reset asserted)
in_data  input  DATA_W  character from receiver, valid only when in_ready=1
in_ready  input  1  one-cycle strobe: new character available
in_error  input  1  parity error for this character, qualified by in_ready
rd_en  input  1  pop request from consumer
ovf_clr  input  1  clears sticky overflow flag
out_data  output  DATA_W  head-of-FIFO character (show-ahead)
out_error  output  1  parity flag of head entry
out_valid  output  1  FIFO not empty
full  output  1  FIFO holds DEPTH entries
count  output  DEPTH_LOG2+1  current occupancy, 0..DEPTH
overflow  output  1  sticky: a character was dropped because FIFO was full
err_count  output  8  saturating count of parity-errored characters received

Behaviour:
- Reset (rst=0, asynchronous): read/write pointers=0, count=0, out_valid=0, full=0, overflow=0, err_count=0. Storage contents are don't-care; out_data/out_error read 0 while empty.
- Storage: DEPTH entries of {in_error, in_data}; pointers DEPTH_LOG2 bits wide, wrap naturally from DEPTH-1 to 0.
- Write: on a clk edge with in_ready=1, when count<DEPTH or a pop happens in the same cycle, store the entry at wr_ptr and increment wr_ptr.
- Pop: on a clk edge with rd_en=1 and out_valid=1, increment rd_ptr. rd_en while empty is ignored and has no side effects.
- Show-ahead: out_data/out_error always reflect the entry at rd_ptr. A write into an empty FIFO sets out_valid=1 and presents the data on the cycle after the in_ready edge (1-cycle latency). No extra read latency.
- Simultaneous write and pop: both take effect and count is unchanged. This is allowed when full: the new entry is accepted and the oldest entry is popped.
- count is +1 on write only, -1 on pop only, unchanged otherwise. full = (count==DEPTH). out_valid = (count!=0).
- Overflow: in_ready=1 while full and no pop in that cycle drops the character. Pointers are unchanged and overflow is set to 1. Overflow clears only when ovf_clr=1. If a set and a clear occur in the same cycle, set wins.
- err_count increments on every in_ready with in_error=1, including dropped characters, and saturates at 255.
- in_ready is assumed to be at most one cycle wide per character. The block does not edge-detect it.
- All outputs are registered or decoded only from registered state. There are no combinational paths from inputs to outputs.

Optional Feature:
Macro RX_DROP_PARITY_ERR_EN.
- Defined: characters with in_error=1 are never written to the FIFO. They still increment err_count and never set overflow. out_error is tied to 0.
- Undefined: errored characters are stored with their flag, as described above.

Test Plan:
- Reset then idle -> out_valid=0, count=0, full=0, overflow=0, err_count=0. Pulse rd_en -> no change.
- Single strobe in_data=7'h41, in_error=0 -> next cycle out_valid=1, out_data=7'h41, count=1. Pulse rd_en -> out_valid=0, count=0.
- Write 8 characters 7'h10..7'h17 -> full=1, count=8. A ninth strobe (7'h18) without pop -> overflow=1, count stays 8. Then pop 8 times -> order 7'h10..7'h17; pointers have wrapped. ovf_clr -> overflow=0.
- With full=1, assert in_ready (7'h20) and rd_en in the same cycle -> count=8, overflow=0, and 7'h20 emerges last.
- 300 strobes with in_error=1 interleaved with pops -> err_count=255 (saturated). With the macro undefined, out_error=1 on each popped entry. With RX_DROP_PARITY_ERR_EN defined, out_valid stays 0 throughout.
- Assert rst=0 mid-burst with count=5 -> all outputs return to reset values immediately, without waiting for a clk edge.
